// File: rtl/tag_fifo_if.sv
// Dispatch/CDB-facing signal bundle for the free-tag pool.
// The slave modport is the pool; the master modport is dispatch plus CDB.
interface tag_fifo_if #(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned PTR_W = 6
);
    logic             pop_req;
    logic [TAG_W-1:0] tag_out;
    logic             tag_valid;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [PTR_W:0]   free_count;
    logic             full;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output pop_req, cdb_valid, cdb_tag,
        input  tag_out, tag_valid, free_count, full, err_overflow, err_underflow
    );

    modport slave (
        input  pop_req, cdb_valid, cdb_tag,
        output tag_out, tag_valid, free_count, full, err_overflow, err_underflow
    );
endinterface

// File: rtl/tag_fifo.sv
// Free rename-tag pool: a circular buffer preloaded with every tag at reset.
// Dispatch pops the head (first-word-fall-through); the CDB pushes retired tags back.
module tag_fifo #(
    parameter int unsigned TAG_W = 6,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned PTR_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    tag_fifo_if.slave  bus
);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic             empty, full_s, pop_ok, push_ok;

    // A full pool still accepts a return when a pop frees a slot in the same cycle.
    always_comb begin
        empty     = (count_q == '0);
        full_s    = (count_q == CNT_W'(DEPTH));
        pop_ok    = bus.pop_req & ~empty;
        push_ok   = bus.cdb_valid & (~full_s | pop_ok);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        err_ovf_d = err_ovf_q | (bus.cdb_valid & ~push_ok);
        err_unf_d = err_unf_q | (bus.pop_req & ~pop_ok);
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= CNT_W'(DEPTH);
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Reset reloads the identity mapping so every tag starts out free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(i);
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.cdb_tag;
        end
    end

    assign bus.tag_out       = mem_q[rd_ptr_q];
    assign bus.tag_valid     = ~empty;
    assign bus.free_count    = count_q;
    assign bus.full          = full_s;
    assign bus.err_overflow  = err_ovf_q;
    assign bus.err_underflow = err_unf_q;
endmodule

// File: tb/tb_tag_fifo.sv
// Bench for tag_fifo: a queue model checked every negedge plus directed literal checks.
module tb_tag_fifo;
    localparam int unsigned TAG_W = 6;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned PTR_W = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    tag_fifo_if #(.TAG_W(TAG_W), .PTR_W(PTR_W)) bus ();

    tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [TAG_W-1:0] mq [$];
    bit               m_ovf;
    bit               m_unf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(TAG_W'(i));
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Pool model: a queue of free tags, popped at the front and refilled at the back.
    initial begin
        bit p_ok;
        bit w_ok;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                p_ok = bus.pop_req && (mq.size() != 0);
                w_ok = bus.cdb_valid && ((mq.size() != DEPTH) || p_ok);
                if (bus.pop_req && !p_ok) m_unf = 1'b1;
                if (bus.cdb_valid && !w_ok) m_ovf = 1'b1;
                if (p_ok) void'(mq.pop_front());
                if (w_ok) mq.push_back(bus.cdb_tag);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_tag_valid", int'(bus.tag_valid), int'(mq.size() != 0));
            if (mq.size() != 0) chk("m_tag_out", int'(bus.tag_out), int'(mq[0]));
            chk("m_free_count", int'(bus.free_count), mq.size());
            chk("m_full", int'(bus.full), int'(mq.size() == DEPTH));
            chk("m_err_ovf", int'(bus.err_overflow), int'(m_ovf));
            chk("m_err_unf", int'(bus.err_underflow), int'(m_unf));
        end
    end

    // Advance one edge, then drive the inputs for the next cycle.
    task automatic cyc(input bit p, input bit c, input logic [TAG_W-1:0] t);
        @(posedge clk);
        #1;
        bus.pop_req   = p;
        bus.cdb_valid = c;
        bus.cdb_tag   = t;
    endtask

    task automatic do_reset();
        bus.pop_req   = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tag_out", int'(bus.tag_out), 0);
        chk("rst_free_count", int'(bus.free_count), 64);
        chk("rst_full", int'(bus.full), 1);
        chk("rst_err_ovf", int'(bus.err_overflow), 0);
        chk("rst_err_unf", int'(bus.err_underflow), 0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bus.pop_req   = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("t1_rst_valid", int'(bus.tag_valid), 1);
        chk("t1_rst_tag", int'(bus.tag_out), 0);
        chk("t1_rst_count", int'(bus.free_count), 64);
        #10 rst_n = 1'b1;

        // 1: three pops give 0,1,2
        cyc(1, 0, '0);
        chk("t1_tag0", int'(bus.tag_out), 0);
        cyc(1, 0, '0);
        chk("t1_tag1", int'(bus.tag_out), 1);
        chk("t1_full_drop", int'(bus.full), 0);
        cyc(1, 0, '0);
        chk("t1_tag2", int'(bus.tag_out), 2);
        chk("t1_count62", int'(bus.free_count), 62);

        // 2: drain the rest, then pop while empty
        for (int i = 3; i < 64; i++) begin
            cyc(1, 0, '0);
            chk("t2_order", int'(bus.tag_out), i);
        end
        cyc(1, 0, '0);
        chk("t2_empty_valid", int'(bus.tag_valid), 0);
        chk("t2_empty_count", int'(bus.free_count), 0);
        chk("t2_unf_before", int'(bus.err_underflow), 0);
        cyc(0, 0, '0);
        chk("t2_unf_set", int'(bus.err_underflow), 1);
        chk("t2_unf_count", int'(bus.free_count), 0);

        // 3: return into empty pool, no bypass
        cyc(0, 1, 6'h2A);
        chk("t3_no_bypass", int'(bus.tag_valid), 0);
        cyc(0, 0, '0);
        chk("t3_valid", int'(bus.tag_valid), 1);
        chk("t3_tag", int'(bus.tag_out), 'h2A);
        chk("t3_count", int'(bus.free_count), 1);

        // 4: return while full
        do_reset();
        cyc(0, 1, 6'd5);
        cyc(0, 0, '0);
        chk("t4_ovf", int'(bus.err_overflow), 1);
        chk("t4_count", int'(bus.free_count), 64);
        chk("t4_tag", int'(bus.tag_out), 0);

        // 5: pop and return while full, then wrap to the returned tag
        do_reset();
        cyc(1, 1, 6'd7);
        chk("t5_alloc", int'(bus.tag_out), 0);
        cyc(0, 0, '0);
        chk("t5_count", int'(bus.free_count), 64);
        chk("t5_no_ovf", int'(bus.err_overflow), 0);
        for (int i = 1; i < 64; i++) begin
            cyc(1, 0, '0);
            chk("t5_order", int'(bus.tag_out), i);
        end
        cyc(0, 0, '0);
        chk("t5_wrap_tag", int'(bus.tag_out), 7);
        chk("t5_wrap_count", int'(bus.free_count), 1);

        // 6: build count=40 with both flags and nonzero pointers, then reset mid-stream
        do_reset();
        cyc(0, 1, 6'd9);
        for (int i = 0; i < 64; i++) cyc(1, 0, '0);
        cyc(1, 0, '0);
        for (int i = 0; i < 45; i++) cyc(0, 1, TAG_W'(i + 10));
        for (int i = 0; i < 5; i++) cyc(1, 0, '0);
        cyc(0, 0, '0);
        chk("t6_pre_count", int'(bus.free_count), 40);
        chk("t6_pre_tag", int'(bus.tag_out), 15);
        chk("t6_pre_ovf", int'(bus.err_overflow), 1);
        chk("t6_pre_unf", int'(bus.err_underflow), 1);
        do_reset();
        cyc(1, 0, '0);
        chk("t6_first_pop", int'(bus.tag_out), 0);
        cyc(0, 0, '0);
        chk("t6_next_head", int'(bus.tag_out), 1);
        chk("t6_count", int'(bus.free_count), 63);

        cyc(0, 0, '0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
- Free-tag pool for the Tomasulo dispatch path.
- Holds the 6-bit rename tags that are not currently bound to a destination register.
- Dispatch pops one tag per renamed instruction; that tag is the wdata0_rst payload written into the register status table (valid bit set by dispatch).
- The CDB returns a tag to the pool when its result broadcasts; the same cdb_valid/cdb_tag pair also clears the RST entry.

Parameters:
- TAG_W, 6, tag width in bits; must match the RST tag field.
- DEPTH, 64, number of tags in circulation; must equal 2**TAG_W.
- PTR_W, 6, pointer width; log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- pop_req  input  1  dispatch consumes the head tag this cycle.
- tag_out  output  TAG_W  head tag, first-word-fall-through.
- tag_valid  output  1  pool non-empty, so tag_out is usable.
- cdb_valid  input  1  tag return strobe.
- cdb_tag  input  TAG_W  tag being returned.
- free_count  output  PTR_W+1  number of tags currently in the pool (0..DEPTH).
- full  output  1  free_count == DEPTH.
- err_overflow  output  1  sticky: a return was attempted while full.
- err_underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage: DEPTH x TAG_W circular buffer with head pointer rd_ptr, tail pointer wr_ptr, and a count register. Pointers wrap modulo DEPTH.
- Reset (rst low, asynchronous; takes effect immediately, including mid-operation):
  - mem[i] = i for i = 0..DEPTH-1.
  - rd_ptr = 0, wr_ptr = 0, count = DEPTH.
  - err_overflow = 0, err_underflow = 0.
  - Resulting outputs: tag_out = 0, tag_valid = 1, full = 1, free_count = 64.
- Release: the first edge after rst rises is a normal operating edge.
- Outputs:
  - tag_out = mem[rd_ptr], combinational (0-cycle read of the head).
  - tag_valid = (count != 0).
  - full and free_count are decoded from registered state only; no input-to-output paths except through tag_out's memory read.
- Pop (pop_req=1 and count!=0):
  - The tag on tag_out during that cycle is the allocated tag.
  - rd_ptr increments at the clock edge; the next head is visible the following cycle.
- Pop while empty: no state change; err_underflow set at the edge.
- Return (cdb_valid=1 and count!=DEPTH):
  - mem[wr_ptr] <= cdb_tag and wr_ptr increments at the edge.
  - No bypass: a tag returned into an empty pool becomes visible (tag_valid=1) one cycle later.
- Return while full: no write; err_overflow set at the edge.
- Simultaneous pop and return:
  - Both are performed when individually legal; count is unchanged.
  - When full, the pop is legal, so the return is also accepted (one slot is freed in the same cycle). This is not an overflow.
  - When empty, the pop is illegal: err_underflow is set, the return is accepted, and count becomes 1.
- Count update: count <= count + push_ok - pop_ok, where:
  - pop_ok = pop_req & (count!=0)
  - push_ok = cdb_valid & ((count!=DEPTH) | pop_ok)
- Error flags are sticky until reset.
- No duplicate-tag checking; returning a tag that is already in the pool is a caller error.
- Single read and single write per cycle; no flush port. Recovery is by reset.

Test Plan:
1. Reset, then pop_req=1 for 3 cycles -> tag_out 0, 1, 2 on consecutive cycles; free_count 64 -> 61; full drops after the first edge.
2. Pop all 64 (tags 0..63 in order) -> tag_valid=0, free_count=0. A further pop sets err_underflow=1 and leaves state unchanged.
3. From empty, cdb_valid=1 with cdb_tag=0x2A -> tag_valid=0 in the same cycle, then 1 with tag_out=0x2A next cycle; free_count=1.
4. Full pool, cdb_valid=1 with cdb_tag=5 and pop_req=0 -> err_overflow=1; free_count stays 64; tag_out stays 0.
5. Full pool, pop_req=1 and cdb_valid=1 with cdb_tag=7 -> tag 0 allocated; free_count stays 64; no error. After 63 further pops, tag_out=7 (wrap-around of wr_ptr and rd_ptr).
6. Assert rst low mid-stream (count=40, pointers nonzero, err flags set) -> immediately tag_out=0, free_count=64, both error flags 0; first pop after release returns tag 0.
